// File: rtl/up_frame_pkg.sv
// Shared types for the uplink frame builder: FSM encoding, buffer entry layout, header field placement.
// No logic; pure declarations plus the header packing helper.
// No flow control of its own.
package up_frame_pkg;

    localparam logic [15:0] SYNC_WORD_DEF = 16'hEB90;

    localparam int HDR_SYNC_LSB = 48;
    localparam int HDR_TAG_LSB  = 40;
    localparam int HDR_SEQ_LSB  = 32;
    localparam int HDR_LEN_LSB  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEAD    = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_TAIL    = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0]  ch;
        logic [63:0] dat;
    } fifo_ent_t;

    // Tag sits in the low 3 bits of its byte; the upper 5 bits stay zero.
    function automatic logic [63:0] build_hdr(input logic [15:0] sync,
                                              input logic [2:0]  tag,
                                              input logic [7:0]  seq,
                                              input logic [15:0] len);
        logic [63:0] hdr;
        hdr = '0;
        hdr[HDR_SYNC_LSB +: 16] = sync;
        hdr[HDR_TAG_LSB  +: 3]  = tag;
        hdr[HDR_SEQ_LSB  +: 8]  = seq;
        hdr[HDR_LEN_LSB  +: 16] = len;
        return hdr;
    endfunction

endpackage

// File: rtl/up_frame_fifo.sv
// Show-ahead synchronous FIFO: rd_dat always shows the head entry, pop advances it.
// Latency: a pushed word is visible at rd_dat the cycle after the push edge.
// Backpressure: push ignored when full unless a pop frees the slot in the same cycle.
module up_frame_fifo #(
    parameter int W  = 67,
    parameter int AW = 9
) (
    input  logic          fifo_rdclk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wr_dat,
    input  logic          pop,
    output logic [W-1:0]  rd_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge fifo_rdclk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge fifo_rdclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/up_frame_builder.sv
// Packs the polled 64-bit upload stream into header + BURST_LEN payload (+ XOR tail when UP_FRAME_CHKSUM_EN).
// Latency: header presented one cycle after the buffer holds a full burst; outputs are registered.
// Backpressure: valid/ready on the uplink side; input has none, so words arriving at a full buffer are dropped (sticky overflow).
module up_frame_builder
    import up_frame_pkg::*;
#(
    parameter int          BURST_LEN = 128,
    parameter int          FIFO_AW   = 9,
    parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF
) (
    input  logic        fifo_rdclk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [63:0] in_data,
    input  logic [2:0]  in_ch,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic        overflow
);

    localparam logic [FIFO_AW:0] BURST_CNT   = (FIFO_AW+1)'(BURST_LEN);
    localparam logic [15:0]      LAST_IDX    = 16'(BURST_LEN - 1);
    localparam logic [15:0]      PRELAST_IDX = 16'(BURST_LEN - 2);
    localparam logic [15:0]      LEN_FIELD   = 16'(BURST_LEN);
`ifdef UP_FRAME_CHKSUM_EN
    localparam logic             EOF_ON_PAYLOAD = 1'b0;
`else
    localparam logic             EOF_ON_PAYLOAD = 1'b1;
`endif
    localparam logic             FIRST_IS_LAST  = (BURST_LEN == 1);

    state_t           state;
    state_t           state_nxt;
    fifo_ent_t        wr_ent;
    fifo_ent_t        rd_ent;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_count;
    logic             burst_rdy;
    logic             xfer;
    logic             last_beat;
    logic             frame_done;
    logic [15:0]      beat_cnt;
    logic [7:0]       seq;
    logic             vld_nxt;
    logic [63:0]      dat_nxt;
    logic             sof_nxt;
    logic             eof_nxt;
`ifdef UP_FRAME_CHKSUM_EN
    logic [63:0]      chk_q;
`endif

    assign wr_ent    = '{ch: in_ch, dat: in_data};
    assign push      = in_valid && (!fifo_full || pop);
    assign burst_rdy = (fifo_count >= BURST_CNT);
    assign xfer      = out_valid && out_ready;
    assign last_beat = (state == ST_PAYLOAD) && (beat_cnt == LAST_IDX);
`ifdef UP_FRAME_CHKSUM_EN
    assign frame_done = (state == ST_TAIL) && xfer;
`else
    assign frame_done = last_beat && xfer;
`endif

    up_frame_fifo #(
        .W  ($bits(fifo_ent_t)),
        .AW (FIFO_AW)
    ) u_fifo (
        .fifo_rdclk (fifo_rdclk),
        .rst_n      (rst_n),
        .push       (push),
        .wr_dat     (wr_ent),
        .pop        (pop),
        .rd_dat     (rd_ent),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    always_ff @(posedge fifo_rdclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (burst_rdy) state_nxt = ST_HEAD;
            ST_HEAD:    if (xfer)      state_nxt = ST_PAYLOAD;
            ST_PAYLOAD: begin
                if (xfer && last_beat) begin
`ifdef UP_FRAME_CHKSUM_EN
                    state_nxt = ST_TAIL;
`else
                    state_nxt = ST_IDLE;
`endif
                end
            end
`ifdef UP_FRAME_CHKSUM_EN
            ST_TAIL:    if (xfer)      state_nxt = ST_IDLE;
`endif
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // The output register is loaded one beat ahead: each load of a payload word pops it,
    // so the head word is consumed on the transfer that precedes its own beat.
    always_comb begin
        vld_nxt = out_valid;
        dat_nxt = out_data;
        sof_nxt = out_sof;
        eof_nxt = out_eof;
        pop     = 1'b0;
        case (state)
            ST_IDLE: begin
                vld_nxt = burst_rdy;
                dat_nxt = burst_rdy ? build_hdr(SYNC_WORD, rd_ent.ch, seq, LEN_FIELD) : '0;
                sof_nxt = burst_rdy;
                eof_nxt = 1'b0;
            end
            ST_HEAD: begin
                if (xfer) begin
                    dat_nxt = rd_ent.dat;
                    sof_nxt = 1'b0;
                    eof_nxt = EOF_ON_PAYLOAD && FIRST_IS_LAST;
                    pop     = !fifo_empty;
                end
            end
            ST_PAYLOAD: begin
                if (xfer) begin
                    if (last_beat) begin
`ifdef UP_FRAME_CHKSUM_EN
                        dat_nxt = chk_q;
                        eof_nxt = 1'b1;
`else
                        vld_nxt = 1'b0;
                        dat_nxt = '0;
                        eof_nxt = 1'b0;
`endif
                    end else begin
                        dat_nxt = rd_ent.dat;
                        eof_nxt = EOF_ON_PAYLOAD && (beat_cnt == PRELAST_IDX);
                        pop     = !fifo_empty;
                    end
                end
            end
`ifdef UP_FRAME_CHKSUM_EN
            ST_TAIL: begin
                if (xfer) begin
                    vld_nxt = 1'b0;
                    dat_nxt = '0;
                    eof_nxt = 1'b0;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge fifo_rdclk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            out_valid <= vld_nxt;
            out_data  <= dat_nxt;
            out_sof   <= sof_nxt;
            out_eof   <= eof_nxt;
        end
    end

    always_ff @(posedge fifo_rdclk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            seq      <= '0;
            overflow <= 1'b0;
        end else begin
            if (state == ST_HEAD && xfer) begin
                beat_cnt <= '0;
            end else if (state == ST_PAYLOAD && xfer) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (frame_done) begin
                seq <= seq + 1'b1;
            end
            if (in_valid && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef UP_FRAME_CHKSUM_EN
    // Pops happen exactly once per payload word, so folding at pop time covers the whole burst.
    always_ff @(posedge fifo_rdclk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= '0;
        end else if (pop) begin
            chk_q <= (state == ST_HEAD) ? rd_ent.dat : (chk_q ^ rd_ent.dat);
        end
    end
`endif

endmodule

// File: tb/tb_up_frame_builder.sv
// Scoreboard bench for up_frame_builder: expected beats queued at stimulus time, monitor compares on each transfer.
module tb_up_frame_builder;

    localparam int BURST = 128;

    typedef struct packed {
        logic        sof;
        logic        eof;
        logic [63:0] dat;
    } beat_t;

    logic        fifo_rdclk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] in_data;
    logic [2:0]  in_ch;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_sof;
    logic        out_eof;
    logic        overflow;

    beat_t      exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_xfer   = 0;
    int         ready_mode = 0;
    logic [7:0] exp_seq  = 8'd0;
    logic       mon_stall = 1'b0;
    beat_t      mon_prev;
    beat_t      mon_exp;

    always #5 fifo_rdclk = ~fifo_rdclk;

    up_frame_builder dut (
        .fifo_rdclk (fifo_rdclk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ch      (in_ch),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .overflow   (overflow)
    );

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected frame: header, BURST words base..base+BURST-1, then tail when the checksum is built in.
    task automatic exp_frame(input logic [63:0] base, input logic [2:0] tag);
        beat_t       b;
        logic [63:0] x;
        x = '0;
        b = '{sof: 1'b1, eof: 1'b0, dat: {16'hEB90, 5'b0, tag, exp_seq, 16'(BURST), 16'h0000}};
        exp_q.push_back(b);
        for (int i = 0; i < BURST; i++) begin
            b.sof = 1'b0;
            b.dat = base + 64'(i);
`ifdef UP_FRAME_CHKSUM_EN
            b.eof = 1'b0;
`else
            b.eof = (i == BURST - 1);
`endif
            x = x ^ b.dat;
            exp_q.push_back(b);
        end
`ifdef UP_FRAME_CHKSUM_EN
        b = '{sof: 1'b0, eof: 1'b1, dat: x};
        exp_q.push_back(b);
`endif
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic push_words(input logic [63:0] base, input logic [2:0] tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge fifo_rdclk); #1;
            in_valid = 1'b1;
            in_data  = base + 64'(i);
            in_ch    = tag;
        end
        @(posedge fifo_rdclk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge fifo_rdclk);
            c++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d beats still pending after %0d cycles, expected 0", name, exp_q.size(), budget);
        end
        repeat (4) @(posedge fifo_rdclk);
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge fifo_rdclk); #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ~out_ready;
            endcase
        end
    end

    // Monitor: compares every transfer against the queue and checks the beat holds while stalled.
    initial begin
        forever begin
            @(negedge fifo_rdclk);
            if (!rst_n) begin
                mon_stall = 1'b0;
            end else begin
                if (mon_stall) begin
                    check("stall_valid_held", 66'(out_valid), 66'd1);
                    check("stall_beat_held", {out_sof, out_eof, out_data}, mon_prev);
                end
                if (out_valid && out_ready) begin
                    n_xfer++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got sof=%b eof=%b data=%h, expected no beat",
                                 out_sof, out_eof, out_data);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("beat", {out_sof, out_eof, out_data}, mon_exp);
                    end
                end
                mon_stall = out_valid && !out_ready;
                mon_prev  = '{sof: out_sof, eof: out_eof, dat: out_data};
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_ch    = '0;
        repeat (3) @(posedge fifo_rdclk);
        #1 rst_n = 1'b1;
        @(negedge fifo_rdclk);
        check("reset_out_valid", 66'(out_valid), 66'd0);
        check("reset_out_data",  66'(out_data),  66'd0);
        check("reset_out_sof",   66'(out_sof),   66'd0);
        check("reset_out_eof",   66'(out_eof),   66'd0);
        check("reset_overflow",  66'(overflow),  66'd0);

        // Frame of 1..128 tag 2: literal header and one-cycle header latency.
        ready_mode = 1;
        exp_frame(64'd1, 3'd2);
        push_words(64'd1, 3'd2, BURST);
        @(negedge fifo_rdclk);
        @(negedge fifo_rdclk);
        check("t1_header_literal", {out_sof, out_eof, out_data}, {2'b10, 64'hEB90_0200_0080_0000});
        wait_drain("t1_drain", 400);

        // 127 words produce nothing; the 128th starts a frame one cycle later.
        exp_frame(64'd1001, 3'd1);
        push_words(64'd1001, 3'd1, BURST - 1);
        repeat (5) @(negedge fifo_rdclk);
        check("t2_no_frame_127", 66'(out_valid), 66'd0);
        push_words(64'd1128, 3'd1, 1);
        @(negedge fifo_rdclk);
        check("t2_valid_same_cycle", 66'(out_valid), 66'd0);
        @(negedge fifo_rdclk);
        check("t2_header_next_cycle", {out_valid, out_sof}, 66'b11);
        wait_drain("t2_drain", 400);

        // Ready toggling every cycle.
        ready_mode = 2;
        exp_frame(64'd2001, 3'd3);
        push_words(64'd2001, 3'd3, BURST);
        wait_drain("t3_drain", 800);

        // 513 words with the uplink stalled: 513th is dropped, 512 framed intact.
        ready_mode = 0;
        for (int f = 0; f < 4; f++) exp_frame(64'd5001 + 64'(f * BURST), 3'd3);
        push_words(64'd5001, 3'd3, 512);
        @(negedge fifo_rdclk);
        check("t4_no_overflow_512", 66'(overflow), 66'd0);
        push_words(64'd5513, 3'd3, 1);
        @(negedge fifo_rdclk);
        check("t4_overflow_513", 66'(overflow), 66'd1);
        ready_mode = 1;
        wait_drain("t4_drain", 2000);

        // 257 frames: sequence number wraps through 255 -> 0 in the headers.
        for (int f = 0; f < 257; f++) begin
            exp_frame({32'(f), 32'd1}, 3'd4);
            push_words({32'(f), 32'd1}, 3'd4, BURST);
            repeat (4) @(posedge fifo_rdclk);
        end
        wait_drain("t5_drain", 2000);

        // Reset in the middle of the payload, then a clean frame with seq restarted.
        exp_frame(64'd7001, 3'd1);
        target = n_xfer + 61;
        push_words(64'd7001, 3'd1, BURST);
        for (int c = 0; c < 400 && n_xfer < target; c++) @(negedge fifo_rdclk);
        check("t6_reached_beat60", 66'(n_xfer >= target), 66'd1);
        @(posedge fifo_rdclk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        exp_seq = 8'd0;
        #1;
        check("t6_rst_out_valid", 66'(out_valid), 66'd0);
        check("t6_rst_out_data",  66'(out_data),  66'd0);
        check("t6_rst_sof_eof",   {out_sof, out_eof}, 66'd0);
        check("t6_rst_overflow",  66'(overflow),  66'd0);
        repeat (3) @(posedge fifo_rdclk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge fifo_rdclk);
        check("t6_no_partial_frame", 66'(out_valid), 66'd0);
        exp_frame(64'd7201, 3'd1);
        push_words(64'd7201, 3'd1, BURST);
        wait_drain("t6_drain", 400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
